// File: rtl/wb_pkg.sv
// Shared types for the register-file write arbiter: FSM states, buffered write entry,
// and a helper that turns a destination register into a one-hot pending mask.
package wb_pkg;
  localparam int WB_WIDTH  = 32;
  localparam int REG_COUNT = 32;

  typedef enum logic {
    S_NORMAL = 1'b0,
    S_DRAIN  = 1'b1
  } wb_state_t;

  typedef struct packed {
    logic [4:0]          rd;
    logic [WB_WIDTH-1:0] data;
  } wb_entry_t;

  function automatic logic [REG_COUNT-1:0] rd_onehot(input logic [4:0] rd);
    return REG_COUNT'(1) << rd;
  endfunction
endpackage

// File: rtl/wb_fifo.sv
// Buffer for secondary results waiting for a free write port; also exposes each slot's
// rd and valid bit so the top can build the pending-register mask.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           push_i,
  input  wb_entry_t                      push_entry_i,
  input  logic                           pop_i,
  output wb_entry_t                      head_o,
  output logic [$clog2(DEPTH):0]         count_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic [DEPTH-1:0][4:0]          entry_rd_o,
  output logic [DEPTH-1:0]               entry_vld_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t [DEPTH-1:0] mem_q;
  logic [DEPTH-1:0]      vld_q, vld_d;
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q, count_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    vld_d = vld_q;
    if (pop_i)  vld_d[rd_ptr_q] = 1'b0;
    if (push_i) vld_d[wr_ptr_q] = 1'b1;
    count_d = count_q + CW'(push_i) - CW'(pop_i);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      mem_q    <= '0;
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_entry_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + PW'(1);
      vld_q   <= vld_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) entry_rd_o[i] = mem_q[i].rd;
  end

  assign entry_vld_o = vld_q;
  assign head_o      = mem_q[rd_ptr_q];
  assign count_o     = count_q;
  assign full_o      = (count_q == CW'(DEPTH));
  assign empty_o     = (count_q == '0);
endmodule

// File: rtl/wb_write_arbiter.sv
// Merges in-order writeback (priority, no backpressure) and a buffered long-latency result
// stream onto the single register-file write port. Optional WB_BYPASS_EN: idle-port secondary bypass.
module wb_write_arbiter
  import wb_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     pri_valid_i,
  input  logic [4:0]               pri_rd_i,
  input  logic [WIDTH-1:0]         pri_data_i,
  input  logic                     sec_valid_i,
  input  logic [4:0]               sec_rd_i,
  input  logic [WIDTH-1:0]         sec_data_i,
  output logic                     sec_ready_o,
  output logic [4:0]               a3_o,
  output logic [WIDTH-1:0]         wd3_o,
  output logic                     we3_o,
  output logic                     stall_o,
  output logic [31:0]              pending_o,
  output logic [$clog2(DEPTH):0]   fifo_count_o
);
  localparam int SW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;

  wb_state_t             state_q, state_d;
  logic [SW-1:0]         starve_q, starve_d;
  wb_entry_t             head;
  logic                  full, empty, push, pop, bypass;
  logic [DEPTH-1:0][4:0] entry_rd;
  logic [DEPTH-1:0]      entry_vld;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= S_NORMAL;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    we3_o    = 1'b0;
    a3_o     = 5'd0;
    wd3_o    = '0;
    stall_o  = 1'b0;
    pop      = 1'b0;
    bypass   = 1'b0;
    case (state_q)
      S_NORMAL: begin
        if (pri_valid_i) begin
          we3_o = 1'b1;
          a3_o  = pri_rd_i;
          wd3_o = pri_data_i;
        end else if (!empty) begin
          we3_o = 1'b1;
          a3_o  = head.rd;
          wd3_o = WIDTH'(head.data);
          pop   = 1'b1;
`ifdef WB_BYPASS_EN
        end else if (sec_valid_i) begin
          we3_o  = 1'b1;
          a3_o   = sec_rd_i;
          wd3_o  = sec_data_i;
          bypass = 1'b1;
`endif
        end
        // Count consecutive cycles the primary blocks a waiting entry.
        if (!empty && pri_valid_i) begin
          if (starve_q == SW'(STARVE_LIMIT - 1)) begin
            state_d  = S_DRAIN;
            starve_d = '0;
          end else begin
            starve_d = starve_q + SW'(1);
          end
        end else begin
          starve_d = '0;
        end
      end
      S_DRAIN: begin
        stall_o  = 1'b1;
        we3_o    = !empty;
        a3_o     = head.rd;
        wd3_o    = WIDTH'(head.data);
        pop      = !empty;
        state_d  = S_NORMAL;
        starve_d = '0;
      end
      default: state_d = S_NORMAL;
    endcase
    if (a3_o == 5'd0) we3_o = 1'b0;
    if (reset_i) begin
      we3_o   = 1'b0;
      a3_o    = 5'd0;
      wd3_o   = '0;
      stall_o = 1'b0;
      pop     = 1'b0;
      bypass  = 1'b0;
    end
  end

  assign sec_ready_o = !full && !reset_i;
  // x0 results are acknowledged but never occupy a slot.
  assign push = sec_valid_i && sec_ready_o && (sec_rd_i != 5'd0) && !bypass;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .push_i       (push),
    .push_entry_i ('{rd: sec_rd_i, data: WB_WIDTH'(sec_data_i)}),
    .pop_i        (pop),
    .head_o       (head),
    .count_o      (fifo_count_o),
    .full_o       (full),
    .empty_o      (empty),
    .entry_rd_o   (entry_rd),
    .entry_vld_o  (entry_vld)
  );

  always_comb begin
    pending_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_vld[i]) pending_o = pending_o | rd_onehot(entry_rd[i]);
    end
  end
endmodule

// File: tb/tb_wb_write_arbiter.sv
// Bench for wb_write_arbiter: directed scenarios then random traffic, each cycle compared
// against a queue-based reference model of the write-port rules.
module tb_wb_write_arbiter;
  localparam int W  = 32;
  localparam int D  = 4;
  localparam int SL = 8;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          pri_valid_i, sec_valid_i;
  logic [4:0]    pri_rd_i, sec_rd_i;
  logic [W-1:0]  pri_data_i, sec_data_i;
  logic          sec_ready_o, we3_o, stall_o;
  logic [4:0]    a3_o;
  logic [W-1:0]  wd3_o;
  logic [31:0]   pending_o;
  logic [2:0]    fifo_count_o;

  always #5 clk = ~clk;

  wb_write_arbiter #(.WIDTH(W), .DEPTH(D), .STARVE_LIMIT(SL)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .pri_valid_i(pri_valid_i), .pri_rd_i(pri_rd_i), .pri_data_i(pri_data_i),
    .sec_valid_i(sec_valid_i), .sec_rd_i(sec_rd_i), .sec_data_i(sec_data_i),
    .sec_ready_o(sec_ready_o), .a3_o(a3_o), .wd3_o(wd3_o), .we3_o(we3_o),
    .stall_o(stall_o), .pending_o(pending_o), .fifo_count_o(fifo_count_o)
  );

  typedef struct { logic [4:0] rd; logic [31:0] data; } ent_t;
  ent_t mq[$];
  bit   mdrain;
  int   mstarve;
  int   checks = 0;
  int   failures = 0;
  int   stall_seen;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mdrain  = 0;
    mstarve = 0;
  endtask

  // Drive one cycle of inputs, check outputs at the falling edge, advance the model at the rising edge.
  task automatic step(input bit pv, input logic [4:0] prd, input logic [31:0] pd,
                      input bit sv, input logic [4:0] srd, input logic [31:0] sd);
    bit          e_we, sel, popq, byp, rdy, busy;
    logic [4:0]  e_a3;
    logic [31:0] e_wd, e_pend;
    ent_t        ne;
    pri_valid_i = pv; pri_rd_i = prd; pri_data_i = pd;
    sec_valid_i = sv; sec_rd_i = srd; sec_data_i = sd;
    #4;
    e_we = 0; e_a3 = 0; e_wd = 0; sel = 0; popq = 0; byp = 0;
    rdy  = (mq.size() < D);
    busy = (mq.size() > 0) && pv && !mdrain;
    e_pend = 0;
    foreach (mq[i]) e_pend |= (32'd1 << mq[i].rd);
    if (mdrain) begin
      sel = 1; e_a3 = mq[0].rd; e_wd = mq[0].data; popq = 1;
    end else if (pv) begin
      sel = 1; e_a3 = prd; e_wd = pd;
    end else if (mq.size() > 0) begin
      sel = 1; e_a3 = mq[0].rd; e_wd = mq[0].data; popq = 1;
`ifdef WB_BYPASS_EN
    end else if (sv) begin
      sel = 1; e_a3 = srd; e_wd = sd; byp = 1;
`endif
    end
    e_we = sel && (e_a3 != 0);
    if (stall_o) stall_seen++;
    chk("stall", stall_o, mdrain);
    chk("we3", we3_o, e_we);
    chk("sec_ready", sec_ready_o, rdy);
    chk("fifo_count", fifo_count_o, mq.size());
    chk("pending", pending_o, e_pend);
    if (e_we || !sel) begin
      chk("a3", a3_o, e_a3);
      chk("wd3", wd3_o, e_wd);
    end
    @(posedge clk);
    if (popq) void'(mq.pop_front());
    if (sv && rdy && srd != 0 && !byp) begin
      ne.rd = srd; ne.data = sd; mq.push_back(ne);
    end
    if (mdrain) begin
      mdrain = 0; mstarve = 0;
    end else if (busy) begin
      if (mstarve == SL - 1) begin mdrain = 1; mstarve = 0; end
      else mstarve++;
    end else begin
      mstarve = 0;
    end
    #1;
  endtask

  initial begin
    reset_i = 1;
    pri_valid_i = 1; pri_rd_i = 5; pri_data_i = 32'hCAFE_F00D;
    sec_valid_i = 1; sec_rd_i = 9; sec_data_i = 32'h1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we3", we3_o, 0);
    chk("rst_a3", a3_o, 0);
    chk("rst_wd3", wd3_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_pending", pending_o, 0);
    chk("rst_count", fifo_count_o, 0);
    chk("rst_ready", sec_ready_o, 0);
    reset_i = 0;

    // Primary only
    step(1, 5, 32'hDEAD_BEEF, 0, 0, 0);

    // Secondary buffered behind 3 primary cycles
    step(1, 1, 32'h11, 1, 7, 32'h1234);
    chk("pend7_set", pending_o[7], 1);
    step(1, 2, 32'h22, 0, 0, 0);
    step(1, 3, 32'h33, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("pend7_clr", pending_o[7], 0);

    // Fill, then pop+offer refused, accepted next cycle
    for (int i = 0; i < 4; i++) step(1, 12, 32'h1200 + i, 1, 5'(8 + i), 32'hA0 + i);
    chk("full_count", fifo_count_o, 4);
    chk("full_ready", sec_ready_o, 0);
    step(0, 0, 0, 1, 13, 32'hBB);
    chk("refused_count", fifo_count_o, 3);
    step(0, 0, 0, 1, 13, 32'hBB);
    chk("accepted_pend13", pending_o[13], 1);
    repeat (5) step(0, 0, 0, 0, 0, 0);

    // x0 handling
    step(1, 0, 32'h77, 0, 0, 0);
    step(0, 0, 0, 1, 0, 32'h99);
    chk("x0_count", fifo_count_o, 0);

    // Starvation: exactly one drain cycle
    step(1, 20, 32'h2020, 1, 21, 32'h2121);
    stall_seen = 0;
    repeat (12) step(1, 20, 32'h2020, 0, 0, 0);
    chk("drain_once", stall_seen, 1);
    chk("drained_count", fifo_count_o, 0);

    // Reset during the drain cycle
    step(1, 20, 32'h2020, 1, 22, 32'h2222);
    for (int i = 0; i < 20 && !mdrain; i++) step(1, 20, 32'h2020, 0, 0, 0);
    chk("in_drain", stall_o, 1);
    reset_i = 1;
    #1;
    chk("mid_rst_we3", we3_o, 0);
    chk("mid_rst_stall", stall_o, 0);
    chk("mid_rst_count", fifo_count_o, 0);
    chk("mid_rst_pending", pending_o, 0);
    @(posedge clk);
    #1;
    reset_i = 0;
    model_reset();
    step(0, 0, 0, 1, 3, 32'h55);
    step(0, 0, 0, 0, 0, 0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 99) < 55), 5'($urandom_range(0, 31)), $urandom,
           ($urandom_range(0, 99) < 50), 5'($urandom_range(0, 31)), $urandom);
    end
    repeat (6) step(0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
